// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolution side of a 2-bit branch predictor. In-flight predictions are held
//   in order; when the actual outcome of the oldest branch arrives it is compared
//   with that prediction and a registered update pulse goes back to the predictor.
//   A wrong prediction raises mispredict/flush and discards every queued
//   prediction, since all of them are younger than the branch that missed.
//
// Parameters
//   DEPTH  outstanding predictions held (power of two, >= 2)
//   CNT_W  width of the statistics counters
//
// Optional build macro
//   STATS_EN  when defined, builds saturating branch_cnt / mispredict_cnt;
//             otherwise both outputs are tied to 0.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   pred_valid/taken    new prediction from the predictor
//   pred_ready          queue can take a prediction (registered count only)
//   res_valid/taken     actual outcome of the oldest outstanding branch
//   upd_valid/taken     one-cycle outcome update toward the predictor
//   mispredict, flush   one-cycle pulses alongside upd_valid on a wrong guess
//   underflow           sticky: an outcome arrived with nothing queued
//   occupancy           current queue fill level
//   branch_cnt          resolved branches (STATS_EN)
//   mispredict_cnt      mispredicted branches (STATS_EN)
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic                     flush,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispredict_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    logic push, resolve, miss, head;

    // Ready looks only at the registered count: a pop in the same cycle does
    // not open a slot for a push.
    assign pred_ready = (count != FULL) && !reset;
    assign push       = pred_valid && pred_ready;
    assign resolve    = res_valid && (count != '0);
    assign head       = mem[rd_ptr];
    assign miss       = resolve && (head != res_taken);
    assign occupancy  = count;

    // Storage needs no reset: entries are only read when count says they are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pred_taken;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            upd_valid  <= 1'b0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
            flush      <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            upd_valid  <= resolve;
            mispredict <= miss;
            flush      <= miss;
            if (resolve)
                upd_taken <= res_taken;
            // A push in the same cycle cannot satisfy a resolve on an empty queue.
            if (res_valid && count == '0)
                underflow <= 1'b1;

            if (miss) begin
                // Everything queued (including a same-cycle push) is younger
                // than the missed branch, so drop it all.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (resolve)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, resolve})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef STATS_EN
    // Saturating counters, updated on the same edge as upd_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (resolve && branch_cnt != '1)
                branch_cnt <= branch_cnt + 1'b1;
            if (miss && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end
`else
    assign branch_cnt     = '0;
    assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a directed vector table with hand-computed
// expectations, hand sequences for underflow / wrap / counter saturation, and
// random traffic, all checked against a queue-based outcome model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset, pred_valid, pred_taken, res_valid, res_taken;
    logic pred_ready, upd_valid, upd_taken, mispredict, flush, underflow;
    logic [OW-1:0]    occupancy;
    logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_taken(upd_taken),
        .mispredict(mispredict), .flush(flush), .underflow(underflow),
        .occupancy(occupancy), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the outstanding predictions as a plain queue, oldest first.
    bit q[$];
    bit m_uv, m_ut, m_mp, m_uf;
    int m_bc, m_mc;
    localparam int SAT = (1 << CNT_W) - 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input bit pv, input bit pt, input bit rv, input bit rt, input bit rs);
        bit push, res, miss;
        reset = rs; pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        if (rs) begin
            q.delete();
            m_uv = 0; m_ut = 0; m_mp = 0; m_uf = 0; m_bc = 0; m_mc = 0;
        end else begin
            push = pv && (q.size() != DEPTH);
            res  = rv && (q.size() != 0);
            miss = res && (q[0] != rt);
            m_uv = res;
            m_mp = miss;
            if (res) m_ut = rt;
            if (rv && q.size() == 0) m_uf = 1;
            if (res && m_bc < SAT) m_bc++;
            if (miss && m_mc < SAT) m_mc++;
            if (miss) q.delete();
            else begin
                if (res) void'(q.pop_front());
                if (push) q.push_back(pt);
            end
        end
        @(posedge clk); #1;
        check("upd_valid", upd_valid, m_uv);
        check("upd_taken", upd_taken, m_ut);
        check("mispredict", mispredict, m_mp);
        check("flush", flush, m_mp);
        check("underflow", underflow, m_uf);
        check("occupancy", occupancy, q.size());
        check("pred_ready", pred_ready, (!rs && q.size() != DEPTH) ? 1 : 0);
`ifdef STATS_EN
        check("branch_cnt", branch_cnt, m_bc);
        check("mispredict_cnt", mispredict_cnt, m_mc);
`else
        check("branch_cnt", branch_cnt, 0);
        check("mispredict_cnt", mispredict_cnt, 0);
`endif
    endtask

    typedef struct {
        bit pv, pt, rv, rt;
        bit uv, ut, mp, rdy;
        int occ;
    } vec_t;

    initial begin
        vec_t tbl[15];
        int ovf;
        reset = 1; pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
        //        pv pt rv rt   uv ut mp rdy occ
        tbl[0]  = '{1, 1, 0, 0,  0, 0, 0, 1, 1};
        tbl[1]  = '{1, 1, 0, 0,  0, 0, 0, 1, 2};
        tbl[2]  = '{1, 0, 0, 0,  0, 0, 0, 1, 3};
        tbl[3]  = '{0, 0, 1, 1,  1, 1, 0, 1, 2};  // head 1, correct
        tbl[4]  = '{0, 0, 1, 1,  1, 1, 0, 1, 1};  // head 1, correct -> {0}
        tbl[5]  = '{1, 1, 0, 0,  0, 1, 0, 1, 2};
        tbl[6]  = '{1, 1, 0, 0,  0, 1, 0, 1, 3};  // {0,1,1}
        tbl[7]  = '{1, 0, 1, 1,  1, 1, 1, 1, 0};  // miss + push -> all flushed
        tbl[8]  = '{0, 0, 0, 0,  0, 1, 0, 1, 0};
        tbl[9]  = '{1, 1, 0, 0,  0, 1, 0, 1, 1};
        tbl[10] = '{1, 1, 0, 0,  0, 1, 0, 1, 2};
        tbl[11] = '{1, 1, 0, 0,  0, 1, 0, 1, 3};
        tbl[12] = '{1, 1, 0, 0,  0, 1, 0, 0, 4};  // full
        tbl[13] = '{1, 0, 1, 1,  1, 1, 0, 1, 3};  // push rejected while full
        tbl[14] = '{0, 0, 1, 0,  1, 0, 1, 1, 0};  // head 1 vs 0 -> miss

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("reset_ready_low", pred_ready, 0);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].rt, 0);
            check($sformatf("tbl%0d_uv", i), upd_valid, tbl[i].uv);
            check($sformatf("tbl%0d_ut", i), upd_taken, tbl[i].ut);
            check($sformatf("tbl%0d_mp", i), mispredict, tbl[i].mp);
            check($sformatf("tbl%0d_rdy", i), pred_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
        end

        // Empty resolve: no pulse, underflow sticky through idle, cleared by reset
        step(1, 1, 1, 1, 0);
        check("uf_no_pulse", upd_valid, 0);
        check("uf_set", underflow, 1);
        check("uf_push_kept", occupancy, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        check("uf_sticky", underflow, 1);
        step(0, 0, 0, 0, 1);
        check("uf_cleared", underflow, 0);

        // Pointer wrap: push/resolve pairs, alternating correct and wrong outcomes
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            bit p;
            p = 1'($urandom_range(0, 1));
            step(1, p, 0, 0, 0);
            step(0, 0, 1, (i % 2 == 0) ? p : !p, 0);
            check("wrap_ut", upd_taken, (i % 2 == 0) ? p : !p);
            check("wrap_mp", mispredict, i % 2);
        end
        // Overlapped wrap with the queue kept partly full
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1, 1, 1, 1, 0);
            check("wrap_occ_bound", (occupancy <= DEPTH) ? 1 : 0, 1);
        end

        // Random traffic against the model
        ovf = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 60) == 0);
            if (occupancy > DEPTH) ovf++;
        end
        check("rand_occ_bound", ovf, 0);

        // Counter saturation: 5 mispredicting resolves
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0);
            step(0, 0, 1, 0, 0);
        end
`ifdef STATS_EN
        check("sat_mispredict_cnt", mispredict_cnt, 3);
        check("sat_branch_cnt", branch_cnt, 3);
`else
        check("nostats_mispredict_cnt", mispredict_cnt, 0);
        check("nostats_branch_cnt", branch_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
